n_bit_serial_subtractor: RTL and testbench
==========================================

Name: n_bit_serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = num1 - num2 - borrow_in, one bit per clock, LSB first, using a single 1-bit full subtractor cell.
- Area-cheap companion to the combinational n_bit_adder in the arithmetic library.
- Used where latency is acceptable and gate count matters.
- Start/busy/done handshake to the controlling datapath; results are held until the next operation completes.

Parameters:
- N, 8, operand/result width in bits (N >= 2).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when the block is ready (IDLE or DONE).
- num1  input  N  minuend; captured on the accepting edge.
- num2  input  N  subtrahend; captured on the accepting edge.
- borrow_in  input  1  borrow into bit 0; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when diff/borrow/ovf are updated.
- diff  output  N  result register, num1 - num2 - borrow_in modulo 2^N.
- borrow  output  1  borrow out of the MSB (1 means unsigned num1 < num2 + borrow_in).
- ovf  output  1  signed (two's complement) overflow of the subtraction.

Behaviour:
- Reset (async assert, sync-safe deassert inside block): state=IDLE, busy=0, done=0, diff=0, borrow=0, ovf=0, internal regs=0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at a rising edge → capture num1, num2 and borrow_in into shift regs a_sr, b_sr and borrow reg br; bit counter cnt=0; go to RUN.
- RUN, each edge:
  - d = a_sr[0]^b_sr[0]^br.
  - bo = (~a_sr[0]&b_sr[0]) | (~a_sr[0]&br) | (b_sr[0]&br).
  - Shift a_sr and b_sr right by 1; shift d into the MSB of result shift reg r_sr; br<=bo; cnt<=cnt+1.
  - On the edge where cnt==N-2, also record br_msb_in = bo (the borrow into the MSB).
  - On the edge where cnt==N-1, go to DONE and load the output registers:
    - diff <= {d, r_sr[N-1:1]}
    - borrow <= bo
    - ovf <= bo ^ br_msb_in
- DONE: done=1 for exactly one cycle.
  - start=1 in DONE is accepted (back-to-back) → RUN with new operands.
  - Otherwise go to IDLE.
- Latency: start accepted at edge k; results are valid and done=1 after edge k+N. Throughput is one op per N+1 cycles.
- start while in RUN is ignored. The operation in flight is unaffected; no queueing.
- Operand inputs are don't-care except on the accepting edge.
- diff, borrow and ovf change only on the completion edge and hold otherwise, including through IDLE.
- Reset mid-RUN aborts the operation: outputs return to 0, and done does not pulse.
- cnt width is clog2(N). No wrap occurs because RUN exits at N-1.
- borrow_in=1 with num1=num2 yields diff=all-ones, borrow=1.

Decomposition:
- Shared package arith_pkg:
  - State encoding typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Function clog2 for the counter width.
- One natural sub-module: full_subtractor (num1, num2, borrow_in → diff, borrow).
  - Gate-level, mirrors full_adder.
  - Instantiated once for the serial cell.

Test Plan:
- N=8: 100 - 37, borrow_in=0 → done exactly 8 edges after the accepting edge; diff=63, borrow=0, ovf=0; busy high for 8 cycles.
- 5 - 10, borrow_in=0 → diff=251 (0xFB), borrow=1, ovf=0. Then 0 - 0, borrow_in=1 → diff=0xFF, borrow=1, ovf=0.
- Signed overflow:
  - 0x80 - 0x01 → diff=0x7F, borrow=0, ovf=1.
  - 0x7F - 0xFF → diff=0x80, borrow=1, ovf=1.
- start re-pulsed with different operands at cycle 3 of RUN for 100 - 37 → ignored; result still 63; exactly one done pulse.
- start held high continuously with 200 - 50 → done pulses every 9 cycles; diff=150 each time; busy low only in DONE cycles.
- rst_n low at cycle 4 of RUN → outputs 0 immediately (async), no done; after release, a new 9 - 3 → diff=6.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-library types: serial FSM state encoding and width helper.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/n_bit_serial_subtractor_if.sv
// Start/busy/done handshake plus operand and result buses of the serial subtractor.
interface n_bit_serial_subtractor_if #(
  parameter int unsigned N = 8
);

  logic         start;
  logic [N-1:0] num1;
  logic [N-1:0] num2;
  logic         borrow_in;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         borrow;
  logic         ovf;

  modport master (
    output start, num1, num2, borrow_in,
    input  busy, done, diff, borrow, ovf
  );

  modport slave (
    input  start, num1, num2, borrow_in,
    output busy, done, diff, borrow, ovf
  );

endinterface

// File: rtl/n_bit_serial_subtractor_full_subtractor.sv
// Gate-level 1-bit full subtractor: diff = num1 - num2 - borrow_in.
module full_subtractor (
  input  logic num1,
  input  logic num2,
  input  logic borrow_in,
  output logic diff,
  output logic borrow
);

  logic w_x;

  assign w_x    = num1 ^ num2;
  assign diff   = w_x ^ borrow_in;
  assign borrow = (~num1 & num2) | (~num1 & borrow_in) | (num2 & borrow_in);

endmodule

// File: rtl/n_bit_serial_subtractor.sv
// Bit-serial N-bit subtractor, LSB first, one bit per clock through a single
// full-subtractor cell. Results hold until the next operation completes.
module n_bit_serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  n_bit_serial_subtractor_if.slave  bus
);

  localparam int unsigned CW = clog2(N);

  logic [1:0]    r_rst_sync;
  logic          w_rst_n;
  state_e        r_state;
  state_e        w_state_nxt;
  logic          w_accept;
  logic          w_last;
  logic          w_msb_in;
  logic [N-1:0]  r_a_sr;
  logic [N-1:0]  r_b_sr;
  logic [N-1:0]  r_r_sr;
  logic          r_br;
  logic          r_br_msb_in;
  logic [CW-1:0] r_cnt;
  logic          w_d;
  logic          w_bo;
  logic          r_busy;
  logic          r_done;
  logic [N-1:0]  r_diff;
  logic          r_borrow;
  logic          r_ovf;

  // Reset asserts asynchronously, releases two clocks later in this domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n  = r_rst_sync[1];
  assign w_last   = (r_cnt == CW'(N - 1));
  assign w_msb_in = (r_cnt == CW'(N - 2));

  // Serial cell operating on the current LSBs and the running borrow.
  full_subtractor u_fs (
    .num1      (r_a_sr[0]),
    .num2      (r_b_sr[0]),
    .borrow_in (r_br),
    .diff      (w_d),
    .borrow    (w_bo)
  );

  // State register.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; start is only honoured when not in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_RUN;
          w_accept    = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (bus.start) begin
          w_state_nxt = ST_RUN;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake flags, registered from the next state.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_RUN);
      r_done <= (w_state_nxt == ST_DONE);
    end
  end

  // Operand capture, bit-serial shifting and result load on the last bit.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_a_sr      <= '0;
      r_b_sr      <= '0;
      r_r_sr      <= '0;
      r_br        <= 1'b0;
      r_br_msb_in <= 1'b0;
      r_cnt       <= '0;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_accept) begin
      r_a_sr <= bus.num1;
      r_b_sr <= bus.num2;
      r_br   <= bus.borrow_in;
      r_cnt  <= '0;
    end else if (r_state == ST_RUN) begin
      r_a_sr <= {1'b0, r_a_sr[N-1:1]};
      r_b_sr <= {1'b0, r_b_sr[N-1:1]};
      r_r_sr <= {w_d, r_r_sr[N-1:1]};
      r_br   <= w_bo;
      r_cnt  <= r_cnt + CW'(1);
      if (w_msb_in) r_br_msb_in <= w_bo;
      if (w_last) begin
        r_diff   <= {w_d, r_r_sr[N-1:1]};
        r_borrow <= w_bo;
        // Signed overflow: borrow into the MSB differs from borrow out of it.
        r_ovf    <= w_bo ^ r_br_msb_in;
      end
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.diff   = r_diff;
  assign bus.borrow = r_borrow;
  assign bus.ovf    = r_ovf;

endmodule

// File: tb/tb_n_bit_serial_subtractor.sv
// Scoreboard bench for the serial subtractor: acceptances push expected
// results computed with integer arithmetic; a monitor checks each done pulse.
module tb_n_bit_serial_subtractor;

  localparam int unsigned N = 8;

  typedef struct {
    logic [N-1:0] d;
    logic         b;
    logic         o;
    int           acc;
  } exp_t;

  logic clk;
  logic rst_n;
  bit   rst_ok;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   n_done;
  exp_t sb[$];
  int   done_cycs[$];

  n_bit_serial_subtractor_if #(.N(N)) bus ();

  n_bit_serial_subtractor #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer subtraction, unsigned and signed views.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi);
    exp_t e;
    int ur, sr;
    ur    = int'(a) - int'(b) - int'(bi);
    sr    = int'($signed(a)) - int'($signed(b)) - int'(bi);
    e.d   = N'(ur);
    e.b   = (ur < 0);
    e.o   = (sr > 127) || (sr < -128);
    e.acc = 0;
    return e;
  endfunction

  // Acceptor: a start seen while the block is ready is taken on the next edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_ok && rst_n && bus.start && !bus.busy) begin
      e = model(bus.num1, bus.num2, bus.borrow_in);
      e.acc = cyc + 1;
      sb.push_back(e);
    end
  end

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done === 1'b1) begin
      n_done++;
      done_cycs.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        check("diff",    32'(bus.diff),   32'(e.d));
        check("borrow",  32'(bus.borrow), 32'(e.b));
        check("ovf",     32'(bus.ovf),    32'(e.o));
        check("latency", 32'(cyc - e.acc), 32'(N));
      end
    end
  end

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.num1 = a; bus.num2 = b; bus.borrow_in = bi;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.num1 = N'($urandom); bus.num2 = N'($urandom); bus.borrow_in = 1'($urandom);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && bus.busy == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_timeout", 32'(ok), 32'(1));
  endtask

  initial begin
    int bcnt, d0, viol, nint;
    bit seen;
    rst_n = 1'b0; rst_ok = 1'b0;
    bus.start = 1'b0; bus.num1 = '0; bus.num2 = '0; bus.borrow_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_diff",   32'(bus.diff),   32'(0));
    check("rst_borrow", 32'(bus.borrow), 32'(0));
    check("rst_ovf",    32'(bus.ovf),    32'(0));
    check("rst_busy",   32'(bus.busy),   32'(0));
    check("rst_done",   32'(bus.done),   32'(0));
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    rst_ok = 1'b1;

    // 100 - 37 with busy-cycle count.
    issue(8'd100, 8'd37, 1'b0);
    bcnt = 0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (bus.done) begin seen = 1'b1; break; end
      if (bus.busy) bcnt++;
    end
    check("first_done_seen", 32'(seen), 32'(1));
    check("busy_cycles", 32'(bcnt), 32'(N));
    drain();

    issue(8'd5, 8'd10, 1'b0);     drain();
    issue(8'd0, 8'd0, 1'b1);      drain();
    issue(8'h80, 8'h01, 1'b0);    drain();
    issue(8'h7F, 8'hFF, 1'b0);    drain();

    // start re-pulsed mid-RUN must be ignored.
    d0 = n_done;
    issue(8'd100, 8'd37, 1'b0);
    repeat (2) @(posedge clk);
    #1; bus.start = 1'b1; bus.num1 = 8'd11; bus.num2 = 8'd22;
    @(posedge clk); #1; bus.start = 1'b0;
    drain();
    repeat (4) @(posedge clk);
    check("repulse_done_count", 32'(n_done - d0), 32'(1));

    // start held high: back-to-back operations.
    done_cycs.delete();
    viol = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.num1 = 8'd200; bus.num2 = 8'd50; bus.borrow_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (i >= 1 && (bus.busy ^ bus.done) != 1'b1) viol++;
    end
    @(posedge clk); #1; bus.start = 1'b0;
    drain();
    check("hold_busy_vs_done", 32'(viol), 32'(0));
    nint = 0; viol = 0;
    for (int i = 1; i < done_cycs.size(); i++) begin
      nint++;
      if (done_cycs[i] - done_cycs[i-1] != N + 1) viol++;
    end
    check("hold_enough_pulses", 32'(nint >= 3), 32'(1));
    check("hold_period", 32'(viol), 32'(0));

    // Reset mid-RUN.
    d0 = n_done;
    issue(8'd77, 8'd12, 1'b0);
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0; rst_ok = 1'b0;
    #1;
    check("midrst_busy",   32'(bus.busy),   32'(0));
    check("midrst_diff",   32'(bus.diff),   32'(0));
    check("midrst_borrow", 32'(bus.borrow), 32'(0));
    check("midrst_ovf",    32'(bus.ovf),    32'(0));
    sb.delete();
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (4) @(posedge clk);
    check("midrst_no_done", 32'(n_done - d0), 32'(0));
    rst_ok = 1'b1;
    issue(8'd9, 8'd3, 1'b0);
    drain();
    repeat (5) @(posedge clk);
    #1;
    check("hold_in_idle", 32'(bus.diff), 32'(6));

    // Random operations.
    for (int i = 0; i < 40; i++) begin
      issue(N'($urandom), N'($urandom), 1'($urandom));
      drain();
    end

    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
